seq_mul_256: RTL and testbench

//  Sequential 256x256 -> 512-bit unsigned multiplier for GF(2^255-19) arithmetic.

---
 rtl/ed25519_pkg.sv | 19 +
 rtl/mul_limb_256.sv | 14 +
 rtl/seq_mul_256.sv | 112 +++++++++++
 tb/tb_seq_mul_256.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ed25519_pkg.sv
// Shared constants and state encoding for the sequential GF(2^255-19) arithmetic blocks.
package ed25519_pkg;

  localparam int B  = 256;
  localparam int B2 = 512;

  localparam logic [B-1:0] P = (256'd1 << 255) - 256'd19;

  typedef enum logic {
    IDLE,
    MUL
  } seq_state_e;

  // Counter width that stays legal when a product takes a single cycle.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mul_limb_256.sv
// Combinational 256 x LIMB_W unsigned multiply; kept separate so the DSP mapping can be swapped here.
module mul_limb_256
  import ed25519_pkg::*;
#(
  parameter int LIMB_W = 64
) (
  input  logic [B-1:0]        a_i,
  input  logic [LIMB_W-1:0]   limb_i,
  output logic [B+LIMB_W-1:0] p_o
);

  assign p_o = {{LIMB_W{1'b0}}, a_i} * {{B{1'b0}}, limb_i};

endmodule

// File: rtl/seq_mul_256.sv
// Sequential 256x256 -> 512-bit unsigned multiplier, one LIMB_W-bit limb of b per cycle.
// Right-shifting accumulator: the running upper half lives in hi_q, finished low limbs retire into lo_q.
module seq_mul_256
  import ed25519_pkg::*;
#(
  parameter int LIMB_W = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [B-1:0]  a,
  input  logic [B-1:0]  b,
  output logic [B2-1:0] product,
  output logic          done,
  output logic          busy
);

  localparam int NLIMB = B / LIMB_W;
  localparam int CNT_W = cnt_width(NLIMB);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NLIMB - 1);

  if (LIMB_W < 1 || (B % LIMB_W) != 0) begin : g_bad_limb
    $error("seq_mul_256: LIMB_W must divide 256");
  end

  seq_state_e         state_q;
  logic [B-1:0]       a_q, b_q;
  logic [B-1:0]       hi_q, lo_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [B2-1:0]      product_q;
  logic               done_q, busy_q;

  logic [LIMB_W-1:0]   limb;
  logic [B+LIMB_W-1:0] pp;
  logic [B+LIMB_W-1:0] sum_d;
  logic [B-1:0]        hi_d, lo_d;
  logic                accept;

  assign accept = (state_q == IDLE) && start;
  assign limb   = b_q[cnt_q*LIMB_W +: LIMB_W];

  mul_limb_256 #(
    .LIMB_W(LIMB_W)
  ) u_mul_limb (
    .a_i   (a_q),
    .limb_i(limb),
    .p_o   (pp)
  );

  // hi_q + a*limb is always below 2^(256+LIMB_W), so this sum cannot carry out.
  assign sum_d = {{LIMB_W{1'b0}}, hi_q} + pp;
  assign hi_d  = sum_d[B+LIMB_W-1:LIMB_W];

  always_comb begin
    // NOTE: assign the full default before the partial overwrite so no bit of lo_d is left unassigned (no latch).
    lo_d = lo_q;
    lo_d[cnt_q*LIMB_W +: LIMB_W] = sum_d[LIMB_W-1:0];
  end

  // NOTE: operand registers carry no reset; they are only read after an accept has loaded them.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= b;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= MUL;
          end
        end
        MUL: begin
          hi_q <= hi_d;
          lo_q <= lo_d;
          if (cnt_q == LAST) begin
            product_q <= {hi_d, lo_d};
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign product = product_q;
  assign done    = done_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_seq_mul_256.sv
// Self-checking bench for seq_mul_256 at LIMB_W = 64, 32 and 256 against a plain a*b reference.
module tb_seq_mul_256;
  import ed25519_pkg::*;

  localparam int NDUT = 3;

  logic          clk = 1'b0;
  logic          rst_v   [NDUT];
  logic          start_v [NDUT];
  logic [255:0]  a_in, b_in;
  logic [511:0]  prod_v  [NDUT];
  logic          done_v  [NDUT];
  logic          busy_v  [NDUT];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_mul_256 #(.LIMB_W(64)) u_dut64 (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .a(a_in), .b(b_in),
    .product(prod_v[0]), .done(done_v[0]), .busy(busy_v[0])
  );
  seq_mul_256 #(.LIMB_W(32)) u_dut32 (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .a(a_in), .b(b_in),
    .product(prod_v[1]), .done(done_v[1]), .busy(busy_v[1])
  );
  seq_mul_256 #(.LIMB_W(256)) u_dut256 (
    .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .a(a_in), .b(b_in),
    .product(prod_v[2]), .done(done_v[2]), .busy(busy_v[2])
  );

  function automatic int nlimb_of(input int k);
    case (k)
      0:       return 4;
      1:       return 8;
      default: return 1;
    endcase
  endfunction

  function automatic logic [511:0] ref_mul(input logic [255:0] x, input logic [255:0] y);
    logic [511:0] xe, ye;
    xe = {256'b0, x};
    ye = {256'b0, y};
    return xe * ye;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until done, checking busy stays high meanwhile; lat counts edges taken.
  task automatic wait_done(input int k, output int lat, output logic ok);
    lat = 0;
    ok  = 1'b0;
    while (lat < 40) begin
      step();
      lat++;
      if (done_v[k] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      checks++;
      if (busy_v[k] !== 1'b1) begin
        failures++;
        $display("FAIL busy_during_op dut%0d: busy=%b at edge %0d, required 1", k, busy_v[k], lat);
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL done_timeout dut%0d: no done within %0d edges", k, lat);
    end
  endtask

  task automatic run_op(input int k, input logic [255:0] av, input logic [255:0] bv,
                        output logic [511:0] p);
    int   lat;
    logic ok;
    a_in = av;
    b_in = bv;
    start_v[k] = 1'b1;
    step();
    start_v[k] = 1'b0;
    checks++;
    if (busy_v[k] !== 1'b1 || done_v[k] !== 1'b0) begin
      failures++;
      $display("FAIL accept dut%0d: busy=%b done=%b, required busy=1 done=0", k, busy_v[k], done_v[k]);
    end
    wait_done(k, lat, ok);
    p = prod_v[k];
    checks++;
    if (lat != nlimb_of(k)) begin
      failures++;
      $display("FAIL latency dut%0d: got %0d edges, required %0d", k, lat, nlimb_of(k));
    end
    checks++;
    if (busy_v[k] !== 1'b0) begin
      failures++;
      $display("FAIL busy_at_done dut%0d: busy=%b, required 0", k, busy_v[k]);
    end
    step();
    checks++;
    if (done_v[k] !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse_width dut%0d: done=%b one cycle later, required 0", k, done_v[k]);
    end
  endtask

  task automatic test_reset(input int k);
    rst_v[k] = 1'b1;
    step();
    step();
    rst_v[k] = 1'b0;
    checks++;
    if (prod_v[k] !== 512'd0 || done_v[k] !== 1'b0 || busy_v[k] !== 1'b0) begin
      failures++;
      $display("FAIL reset_state dut%0d: product=%h done=%b busy=%b, required all 0",
               k, prod_v[k], done_v[k], busy_v[k]);
    end
  endtask

  task automatic test_zero(input int k);
    logic [511:0] p;
    run_op(k, 256'd0, {256{1'b1}}, p);
    checks++;
    if (p !== 512'd0) begin
      failures++;
      $display("FAIL zero_operand dut%0d: got %h required 0", k, p);
    end
  endtask

  task automatic test_directed(input int k);
    logic [255:0] av [3];
    logic [255:0] bv [3];
    logic [511:0] ev [3];
    logic [511:0] p;
    av[0] = 256'd1;          bv[0] = P - 256'd1;
    ev[0] = {256'd0, P - 256'd1};
    av[1] = {256{1'b1}};    bv[1] = {256{1'b1}};
    ev[1] = {{255{1'b1}}, 1'b0, {255{1'b0}}, 1'b1};
    av[2] = 256'd1 << 64;   bv[2] = 256'd1 << 192;
    ev[2] = 512'd1 << 256;
    for (int i = 0; i < 3; i++) begin
      run_op(k, av[i], bv[i], p);
      checks++;
      if (p !== ev[i]) begin
        failures++;
        $display("FAIL directed%0d dut%0d: got %h required %h", i, k, p, ev[i]);
      end
    end
  endtask

  task automatic test_random(input int k);
    logic [255:0] x, y;
    logic [511:0] p;
    for (int i = 0; i < 8; i++) begin
      x = rand256();
      y = rand256();
      if (i == 6) x = {256{1'b1}};
      if (i == 7) y = {256{1'b1}};
      run_op(k, x, y, p);
      checks++;
      if (p !== ref_mul(x, y)) begin
        failures++;
        $display("FAIL random%0d dut%0d: got %h required %h", i, k, p, ref_mul(x, y));
      end
    end
  endtask

  task automatic test_back_to_back(input int k);
    logic [255:0] x1, y1, x2, y2;
    logic [511:0] e1, e2;
    int   lat;
    logic ok;
    x1 = rand256(); y1 = rand256();
    x2 = rand256(); y2 = rand256();
    e1 = ref_mul(x1, y1);
    e2 = ref_mul(x2, y2);
    a_in = x1; b_in = y1;
    start_v[k] = 1'b1;
    step();
    start_v[k] = 1'b0;
    wait_done(k, lat, ok);
    checks++;
    if (prod_v[k] !== e1) begin
      failures++;
      $display("FAIL b2b_first dut%0d: got %h required %h", k, prod_v[k], e1);
    end
    a_in = x2; b_in = y2;
    start_v[k] = 1'b1;
    step();
    start_v[k] = 1'b0;
    checks++;
    if (busy_v[k] !== 1'b1 || done_v[k] !== 1'b0 || prod_v[k] !== e1) begin
      failures++;
      $display("FAIL b2b_accept dut%0d: busy=%b done=%b product=%h, required busy=1 done=0 old product",
               k, busy_v[k], done_v[k], prod_v[k]);
    end
    wait_done(k, lat, ok);
    checks++;
    if (lat != nlimb_of(k) || prod_v[k] !== e2) begin
      failures++;
      $display("FAIL b2b_second dut%0d: lat=%0d product=%h, required lat=%0d product=%h",
               k, lat, prod_v[k], nlimb_of(k), e2);
    end
    step();
  endtask

  task automatic test_start_while_busy(input int k);
    logic [255:0] x, y;
    logic [511:0] e, p_seen;
    int ndone, first_lat;
    x = rand256(); y = rand256();
    e = ref_mul(x, y);
    p_seen = '0;
    ndone = 0;
    first_lat = 0;
    a_in = x; b_in = y;
    start_v[k] = 1'b1;
    step();
    a_in = rand256();
    b_in = rand256();
    for (int i = 1; i <= nlimb_of(k) + 6; i++) begin
      step();
      if (i == 1) start_v[k] = 1'b0;
      if (i == 3) begin
        a_in = rand256();
        b_in = rand256();
      end
      if (done_v[k] === 1'b1) begin
        ndone++;
        if (ndone == 1) begin
          first_lat = i;
          p_seen = prod_v[k];
        end
      end
    end
    checks++;
    if (ndone != 1 || first_lat != nlimb_of(k)) begin
      failures++;
      $display("FAIL busy_start_ignored dut%0d: done pulses=%0d first at edge %0d, required 1 at edge %0d",
               k, ndone, first_lat, nlimb_of(k));
    end
    checks++;
    if (p_seen !== e || busy_v[k] !== 1'b0) begin
      failures++;
      $display("FAIL busy_operands_held dut%0d: product=%h busy=%b, required %h busy=0",
               k, p_seen, busy_v[k], e);
    end
  endtask

  task automatic test_reset_mid(input int k);
    int   m;
    logic seen;
    logic [511:0] p, pe;
    m = (nlimb_of(k) < 2) ? nlimb_of(k) : 2;
    seen = 1'b0;
    a_in = rand256();
    b_in = rand256();
    start_v[k] = 1'b1;
    step();
    start_v[k] = 1'b0;
    for (int i = 1; i < m; i++) begin
      step();
      if (done_v[k] === 1'b1) seen = 1'b1;
    end
    rst_v[k] = 1'b1;
    step();
    rst_v[k] = 1'b0;
    checks++;
    if (prod_v[k] !== 512'd0 || done_v[k] !== 1'b0 || busy_v[k] !== 1'b0) begin
      failures++;
      $display("FAIL midop_reset_state dut%0d: product=%h done=%b busy=%b, required all 0",
               k, prod_v[k], done_v[k], busy_v[k]);
    end
    for (int i = 0; i < nlimb_of(k) + 3; i++) begin
      step();
      if (done_v[k] === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL midop_no_done dut%0d: done pulsed for abandoned operation", k);
    end
    run_op(k, P - 256'd1, P - 256'd1, p);
    checks++;
    if (p !== ref_mul(P - 256'd1, P - 256'd1)) begin
      failures++;
      $display("FAIL post_reset_square dut%0d: got %h required %h", k, p, ref_mul(P - 256'd1, P - 256'd1));
    end
    pe = {256'd0, P};
    checks++;
    if ((p % pe) !== 512'd1) begin
      failures++;
      $display("FAIL square_mod_p dut%0d: got %h required 1", k, p % pe);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    a_in = '0;
    b_in = '0;
    for (int k = 0; k < NDUT; k++) begin
      rst_v[k]   = 1'b1;
      start_v[k] = 1'b0;
    end
    step();
    step();
    for (int k = 0; k < NDUT; k++) rst_v[k] = 1'b0;

    for (int k = 0; k < NDUT; k++) begin
      test_reset(k);
      test_zero(k);
      test_directed(k);
      test_random(k);
      test_back_to_back(k);
      test_start_while_busy(k);
      test_reset_mid(k);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
